pixel_ray_scheduler: RTL
========================

Name: pixel_ray_scheduler

Overview:
- Issuing end of the per-pixel block/saber selection interface; upstream of the block selector, which detects a new pixel request when its x/y inputs change.
- Scans a full frame in raster order and presents one (x,y) at a time with a per-frame timestamp.
- Holds each coordinate until the selector reports completion, then advances; reports completed pixels, frame boundaries and stalls.

Parameters:
- H_PIXELS, 1024, pixels per line; x range 0..H_PIXELS-1.
- V_PIXELS, 768, lines per frame; y range 0..V_PIXELS-1.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before a pixel is force-advanced.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- enable_in  input  1  level; allows a new frame to start.
- time_in  input  18  free-running game time; sampled at frame start.
- stall_in  input  1  downstream backpressure; blocks advancing to the next pixel.
- done_in  input  1  selector valid_out level.
- x_out  output  11  requested pixel x.
- y_out  output  10  requested pixel y.
- curr_time_out  output  18  frame timestamp.
- pixel_done_out  output  1  one-cycle pulse when the current pixel completes.
- frame_start_out  output  1  one-cycle pulse on the first issue of a frame.
- frame_done_out  output  1  one-cycle pulse when the last pixel completes.
- busy_out  output  1  high in any state except IDLE.
- timeout_err_out  output  1  sticky; set on any forced advance.

Behaviour:
- Reset (async assert, sync release): state IDLE; x_out=1023 and y_out=767 (same as H_PIXELS-1, V_PIXELS-1 at default parameters); curr_time_out=0; all pulses 0; busy_out=0; timeout_err_out=0; armed=0; timeout counter=0.
- Reset mid-frame aborts the frame immediately. No pulses are emitted.
- States:
  - IDLE -> ISSUE when enable_in=1. Load x=0, y=0, curr_time_out<=time_in. frame_start_out pulses in the same cycle the ISSUE coordinates appear on x_out/y_out.
  - ISSUE (1 cycle): coordinates are stable; clear armed and the timeout counter; -> WAIT.
  - WAIT:
    - armed<=1 on any cycle done_in=0 is sampled.
    - Completion = armed && done_in=1. The armed rule prevents a stale done level from the previous pixel counting as completion.
    - On completion: pixel_done_out pulses (x_out/y_out still show the completed pixel); -> ADVANCE.
    - Timeout counter increments each WAIT cycle. On reaching TIMEOUT_CYCLES-1 without completion: set timeout_err_out, pulse pixel_done_out, -> ADVANCE.
  - ADVANCE:
    - If stall_in=1: stay; outputs held.
    - Else if x<H_PIXELS-1: x+1, -> ISSUE.
    - Else if y<V_PIXELS-1: x=0, y+1, -> ISSUE.
    - Else (last pixel): pulse frame_done_out; then -> ISSUE with new frame (x=0, y=0, relatch time, pulse frame_start_out) if enable_in=1, or -> IDLE otherwise.
- x_out/y_out change only on the ADVANCE->ISSUE transition. Consecutive requests always differ in (x,y), including the frame wrap (1023,767)->(0,0), so the selector's change detection always fires.
- curr_time_out is constant for the whole frame.
- Latency per pixel: 1 ISSUE + WAIT duration + >=1 ADVANCE cycle.
- done_in high during ISSUE is ignored.
- enable_in falling mid-frame does not abort; the frame finishes, then the block returns to IDLE.
- timeout_err_out clears only on reset.
- Widths: x counter 11 bits, y counter 10 bits, timeout counter $clog2(TIMEOUT_CYCLES) bits; no overflow is possible within parameter bounds.

Test Plan:
- Reset with enable_in=1, time_in=18'h00123 -> after release, frame_start_out pulses with x_out=0, y_out=0, curr_time_out=0x00123; busy_out=1.
- done_in held 1 from before issue, drops for 2 cycles, rises 14 cycles after ISSUE -> exactly one pixel_done_out pulse, timed on the rise; next request is x=1,y=0.
- Completion at x=1023,y=0 -> next request x=0,y=1; completion at x=1023,y=767 -> frame_done_out pulse, then x=0,y=0 with frame_start_out and a relatched time.
- stall_in=1 for 5 cycles after a completion -> x_out/y_out hold for 5 cycles, no extra pixel_done_out; advance occurs the cycle after stall_in falls.
- done_in stuck 0 -> after 64 WAIT cycles pixel_done_out pulses, timeout_err_out=1 and stays 1; scan continues to the next pixel.
- rst_n_in asserted mid-WAIT at (500,300) -> outputs immediately at reset values (x=1023, y=767, busy_out=0) with no pulses; with enable_in=1 after release, the scan restarts at (0,0).

Source files
------------

// File: rtl/pixel_ray_scheduler.sv
// Raster-order pixel request generator for the block/saber selector.
// Holds each (x,y) until the selector completes it (or a timeout forces it), then advances.
`timescale 1ns/1ps
module pixel_ray_scheduler #(
  parameter int H_PIXELS       = 1024,
  parameter int V_PIXELS       = 768,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        enable_in,
  input  logic [17:0] time_in,
  input  logic        stall_in,
  input  logic        done_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic [17:0] curr_time_out,
  output logic        pixel_done_out,
  output logic        frame_start_out,
  output logic        frame_done_out,
  output logic        busy_out,
  output logic        timeout_err_out
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [10:0]   X_LAST  = 11'(H_PIXELS - 1);
  localparam logic [9:0]    Y_LAST  = 10'(V_PIXELS - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ADV} state_t;

  state_t        r_state;
  logic [10:0]   r_x;
  logic [9:0]    r_y;
  logic [17:0]   r_time;
  logic          r_armed;
  logic [TW-1:0] r_cnt;
  logic          r_pd;
  logic          r_fs;
  logic          r_fd;
  logic          r_busy;
  logic          r_te;
  logic          w_last;

  assign w_last = (r_x == X_LAST) && (r_y == Y_LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
      r_x     <= X_LAST;
      r_y     <= Y_LAST;
      r_time  <= '0;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_pd    <= 1'b0;
      r_fs    <= 1'b0;
      r_fd    <= 1'b0;
      r_busy  <= 1'b0;
      r_te    <= 1'b0;
    end else begin
      r_pd <= 1'b0;
      r_fs <= 1'b0;
      r_fd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable_in) begin
            r_x     <= '0;
            r_y     <= '0;
            r_time  <= time_in;
            r_fs    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_armed <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done level left over from the previous pixel only counts once it has dropped
          if (r_armed && done_in) begin
            r_pd    <= 1'b1;
            r_fd    <= w_last;
            r_state <= S_ADV;
          end else if (r_cnt == TO_LAST) begin
            r_te    <= 1'b1;
            r_pd    <= 1'b1;
            r_fd    <= w_last;
            r_state <= S_ADV;
          end else begin
            r_cnt <= r_cnt + TW'(1);
            if (!done_in) r_armed <= 1'b1;
          end
        end
        S_ADV: begin
          if (!stall_in) begin
            if (r_x < X_LAST) begin
              r_x     <= r_x + 11'd1;
              r_state <= S_ISSUE;
            end else if (r_y < Y_LAST) begin
              r_x     <= '0;
              r_y     <= r_y + 10'd1;
              r_state <= S_ISSUE;
            end else if (enable_in) begin
              r_x     <= '0;
              r_y     <= '0;
              r_time  <= time_in;
              r_fs    <= 1'b1;
              r_state <= S_ISSUE;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign x_out           = r_x;
  assign y_out           = r_y;
  assign curr_time_out   = r_time;
  assign pixel_done_out  = r_pd;
  assign frame_start_out = r_fs;
  assign frame_done_out  = r_fd;
  assign busy_out        = r_busy;
  assign timeout_err_out = r_te;

endmodule
